// File: rtl/alt_dprio_pkg.sv
`default_nettype none
// ============================================================================
// alt_dprio_pkg : shared state encoding and DPRIO address-field constants
// Rev 1.0
// ============================================================================
package alt_dprio_pkg;

    localparam int c_ch_field_lsb  = 12;
    localparam int c_wd_addr_width = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_CRD  = 3'd3,
        ST_CWR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alt_dprio_wait_timer.sv
`default_nettype none
// ============================================================================
// alt_dprio_wait_timer : per-transfer waitrequest counter with expiry flag
// Rev 1.0
// ============================================================================
module alt_dprio_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_last)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    // Flags the stall cycle that would bring the wait count to TIMEOUT_CYCLES.
    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/alt_dprio_rmw_master.sv
`default_nettype none
// ============================================================================
// alt_dprio_rmw_master : masked read / read-modify-write Avalon-MM master for
// the per-channel DPRIO space, with optional chained set-bit RMW and timeout.
// Rev 1.0
// ============================================================================
module alt_dprio_rmw_master
    import alt_dprio_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_ADDR_WIDTH  = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       i_avmm_clk,
    input  logic                       i_resetn,
    input  logic [DATA_WIDTH-1:0]      i_avmm_mreaddata,
    input  logic                       i_avmm_mwaitrequest,
    output logic [ADDR_WIDTH-1:0]      o_avmm_maddress,
    output logic                       o_avmm_mread,
    output logic                       o_avmm_mwrite,
    output logic [DATA_WIDTH-1:0]      o_avmm_mwritedata,
    output logic                       o_avmm_marbiterlock,
    input  logic                       i_ir_trigger,
    input  logic                       i_ir_rwn,
    input  logic [CH_ADDR_WIDTH-1:0]   i_ir_chaddress,
    input  logic [c_wd_addr_width-1:0] i_ir_wdaddress,
    input  logic [DATA_WIDTH-1:0]      i_ir_writedata,
    input  logic [DATA_WIDTH-1:0]      i_ir_writemask,
    input  logic                       i_ir_chain_en,
    input  logic [c_wd_addr_width-1:0] i_ir_chain_wdaddress,
    input  logic [DATA_WIDTH-1:0]      i_ir_chain_setmask,
    output logic                       o_ir_done,
    output logic                       o_ir_error,
    output logic [DATA_WIDTH-1:0]      o_ir_readdata
);

    localparam logic [CH_ADDR_WIDTH:0] c_num_ch = (CH_ADDR_WIDTH+1)'(NUM_CHANNELS);

    function automatic logic [ADDR_WIDTH-1:0] dprio_addr(input logic [CH_ADDR_WIDTH-1:0] ch,
                                                         input logic [c_wd_addr_width-1:0] wd);
        return (ADDR_WIDTH'(ch) << c_ch_field_lsb) | ADDR_WIDTH'(wd);
    endfunction

    state_t                       r_state, w_next;
    logic                         r_rwn, r_chain_en;
    logic [CH_ADDR_WIDTH-1:0]     r_ch;
    logic [c_wd_addr_width-1:0]   r_chain_addr;
    logic [DATA_WIDTH-1:0]        r_wdata, r_mask, r_setmask;

    logic                         w_accept, w_ch_bad, w_xfer, w_complete, w_timeout;
    logic                         w_mread_n, w_mwrite_n, w_done_n, w_err_n;
    logic [ADDR_WIDTH-1:0]        w_addr_n;
    logic [DATA_WIDTH-1:0]        w_wdata_n, w_rdata_n;

    assign w_accept   = (r_state == ST_IDLE) && i_ir_trigger;
    assign w_ch_bad   = {1'b0, i_ir_chaddress} >= c_num_ch;
    assign w_xfer     = o_avmm_mread || o_avmm_mwrite;
    assign w_complete = w_xfer && !i_avmm_mwaitrequest;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            alt_dprio_wait_timer #(
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_wait_timer (
                .clk     (i_avmm_clk),
                .rst_n   (i_resetn),
                .clear   (!w_xfer || !i_avmm_mwaitrequest),
                .enable  (w_xfer && i_avmm_mwaitrequest),
                .expired (w_timeout)
            );
        end else begin : g_no_timer
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_ir_trigger) w_next = w_ch_bad ? ST_DONE : ST_RD;
            ST_RD:   if (w_complete) w_next = r_rwn ? ST_DONE : ST_WR;
                     else if (w_timeout) w_next = ST_DONE;
            ST_WR:   if (w_complete) w_next = r_chain_en ? ST_CRD : ST_DONE;
                     else if (w_timeout) w_next = ST_DONE;
            ST_CRD:  if (w_complete) w_next = ST_CWR;
                     else if (w_timeout) w_next = ST_DONE;
            ST_CWR:  if (w_complete || w_timeout) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        w_mread_n  = (w_next == ST_RD) || (w_next == ST_CRD);
        w_mwrite_n = (w_next == ST_WR) || (w_next == ST_CWR);
        w_done_n   = (w_next == ST_DONE);
        w_addr_n   = o_avmm_maddress;
        w_wdata_n  = o_avmm_mwritedata;
        w_err_n    = o_ir_error;
        w_rdata_n  = o_ir_readdata;
        if (w_accept) begin
            w_addr_n = dprio_addr(i_ir_chaddress, i_ir_wdaddress);
            w_err_n  = w_ch_bad;
        end
        if ((r_state == ST_RD) && w_complete) begin
            w_rdata_n = i_avmm_mreaddata & r_mask;
            w_wdata_n = (i_avmm_mreaddata & ~r_mask) | (r_wdata & r_mask);
        end
        if ((r_state == ST_WR) && w_complete && r_chain_en) begin
            w_addr_n = dprio_addr(r_ch, r_chain_addr);
        end
        if ((r_state == ST_CRD) && w_complete) begin
            w_wdata_n = i_avmm_mreaddata | r_setmask;
        end
        if (w_timeout) begin
            w_err_n = 1'b1;
        end
    end

    always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state             <= ST_IDLE;
            o_avmm_maddress     <= '0;
            o_avmm_mread        <= 1'b0;
            o_avmm_mwrite       <= 1'b0;
            o_avmm_mwritedata   <= '0;
            o_avmm_marbiterlock <= 1'b0;
            o_ir_done           <= 1'b0;
            o_ir_error          <= 1'b0;
            o_ir_readdata       <= '0;
        end else begin
            r_state             <= w_next;
            o_avmm_maddress     <= w_addr_n;
            o_avmm_mread        <= w_mread_n;
            o_avmm_mwrite       <= w_mwrite_n;
            o_avmm_mwritedata   <= w_wdata_n;
            o_avmm_marbiterlock <= w_mread_n || w_mwrite_n;
            o_ir_done           <= w_done_n;
            o_ir_error          <= w_err_n;
            o_ir_readdata       <= w_rdata_n;
        end
    end

    always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rwn        <= 1'b0;
            r_chain_en   <= 1'b0;
            r_ch         <= '0;
            r_chain_addr <= '0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_setmask    <= '0;
        end else if (w_accept) begin
            r_rwn        <= i_ir_rwn;
            r_chain_en   <= i_ir_chain_en;
            r_ch         <= i_ir_chaddress;
            r_chain_addr <= i_ir_chain_wdaddress;
            r_wdata      <= i_ir_writedata;
            r_mask       <= i_ir_writemask;
            r_setmask    <= i_ir_chain_setmask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alt_dprio_rmw_master.sv
`default_nettype none
// ============================================================================
// tb_alt_dprio_rmw_master : directed and randomized checks against a memory
// model of the DPRIO space. Rev 1.0
// ============================================================================
module tb_alt_dprio_rmw_master;

    localparam int NCH = 3;
    localparam int TMO = 8;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] rdata, maddr, mwdata, wdata, wmask, setmask, ird;
    logic        waitreq, mread, mwrite, lock, trig, rwn, chain_en, done, err;
    logic [1:0]  chaddr;
    logic [11:0] wdaddr, cwd;

    always #5 clk = ~clk;

    alt_dprio_rmw_master #(
        .NUM_CHANNELS (NCH), .CH_ADDR_WIDTH (2), .ADDR_WIDTH (16),
        .DATA_WIDTH (16), .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_avmm_clk (clk), .i_resetn (resetn),
        .i_avmm_mreaddata (rdata), .i_avmm_mwaitrequest (waitreq),
        .o_avmm_maddress (maddr), .o_avmm_mread (mread), .o_avmm_mwrite (mwrite),
        .o_avmm_mwritedata (mwdata), .o_avmm_marbiterlock (lock),
        .i_ir_trigger (trig), .i_ir_rwn (rwn), .i_ir_chaddress (chaddr),
        .i_ir_wdaddress (wdaddr), .i_ir_writedata (wdata), .i_ir_writemask (wmask),
        .i_ir_chain_en (chain_en), .i_ir_chain_wdaddress (cwd),
        .i_ir_chain_setmask (setmask), .o_ir_done (done), .o_ir_error (err),
        .o_ir_readdata (ird)
    );

    int          n_checks = 0, n_fail = 0;
    int          viol, lock_cycles, done_cycles, left;
    int          ws_q[$];
    xfer_t       log_q[$];
    logic [15:0] mem [logic [15:0]];
    logic [15:0] last_rd = 16'h0;
    bit          in_xfer, prev_stall, prev_rd, prev_wr;
    logic [15:0] prev_addr, prev_wd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    // Slave with per-transfer wait plan, plus bus-rule monitor.
    initial begin
        waitreq = 1'b0; rdata = 16'h0; in_xfer = 0; left = 0; prev_stall = 0;
        viol = 0; lock_cycles = 0; done_cycles = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_xfer = 0; waitreq = 1'b0; prev_stall = 0;
                continue;
            end
            if (mread && mwrite) viol++;
            if ((mread || mwrite) && !lock) viol++;
            if (prev_stall && (mread || mwrite) &&
                (mread != prev_rd || mwrite != prev_wr || maddr != prev_addr || mwdata != prev_wd))
                viol++;
            if (lock) lock_cycles++;
            if (done) done_cycles++;
            if (mread || mwrite) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    left = (ws_q.size() > 0) ? ws_q.pop_front() : 0;
                end
                if (left > 0) begin
                    waitreq = 1'b1; left--; rdata = 16'($urandom);
                end else begin
                    waitreq = 1'b0; in_xfer = 0;
                    if (mread) begin
                        rdata = mem_rd(maddr);
                        log_q.push_back('{wr: 1'b0, addr: maddr, data: rdata});
                    end else begin
                        mem[maddr] = mwdata;
                        log_q.push_back('{wr: 1'b1, addr: maddr, data: mwdata});
                    end
                end
            end else begin
                in_xfer = 0; waitreq = 1'b0;
            end
            prev_stall = (mread || mwrite) && waitreq;
            prev_rd = mread; prev_wr = mwrite; prev_addr = maddr; prev_wd = mwdata;
        end
    end

    task automatic run_op(input string tag, input bit rd, input logic [1:0] c, input logic [11:0] a,
                          input logic [15:0] d, input logic [15:0] m, input bit ch_en,
                          input logic [11:0] ca, input logic [15:0] sm,
                          input int w0, input int w1, input int w2, input int w3, input bit retrig);
        xfer_t       exp_q[$];
        int          ws[4];
        int          lat, got, nsteps, nlog;
        bit          exp_err, valid;
        logic [15:0] pa, pca, old, nw, crd;
        ws = '{w0, w1, w2, w3};
        exp_err = 0; lat = 1;
        valid = int'(c) < NCH;
        pa  = 16'(int'(c) * 4096 + int'(a));
        pca = 16'(int'(c) * 4096 + int'(ca));
        if (!valid) begin
            exp_err = 1;
        end else begin
            old = mem_rd(pa);
            nw  = (old & ~m) | (d & m);
            crd = (pca == pa) ? nw : mem_rd(pca);
            exp_q.push_back('{wr: 1'b0, addr: pa, data: old});
            if (!rd) begin
                exp_q.push_back('{wr: 1'b1, addr: pa, data: nw});
                if (ch_en) begin
                    exp_q.push_back('{wr: 1'b0, addr: pca, data: crd});
                    exp_q.push_back('{wr: 1'b1, addr: pca, data: crd | sm});
                end
            end
            nsteps = exp_q.size();
            for (int i = 0; i < nsteps; i++) begin
                if (ws[i] >= TMO) begin
                    lat += TMO; exp_err = 1;
                    while (exp_q.size() > i) void'(exp_q.pop_back());
                    break;
                end
                lat += ws[i] + 1;
            end
            if (exp_q.size() > 0) last_rd = old & m;
        end

        ws_q.delete();
        for (int i = 0; i < 4; i++) ws_q.push_back(ws[i]);
        log_q.delete();
        @(negedge clk);
        lock_cycles = 0; done_cycles = 0; viol = 0;
        trig = 1'b1; rwn = rd; chaddr = c; wdaddr = a; wdata = d; wmask = m;
        chain_en = ch_en; cwd = ca; setmask = sm;
        @(negedge clk);
        trig = 1'b0;
        rwn = 1'($urandom); chaddr = 2'($urandom); wdaddr = 12'($urandom); wdata = 16'($urandom);
        wmask = 16'($urandom); chain_en = 1'($urandom); cwd = 12'($urandom); setmask = 16'($urandom);
        got = 1;
        while (!done && got < 200) begin
            trig = retrig && (got == 2);
            @(negedge clk);
            got++;
        end
        trig = 1'b0;
        check_eq({tag, ".latency"}, got, lat);
        check_eq({tag, ".error"}, err, exp_err);
        check_eq({tag, ".readdata"}, ird, last_rd);
        check_eq({tag, ".idle_bus_at_done"}, {mread, mwrite, lock}, 3'b000);
        repeat (3) @(negedge clk);
        check_eq({tag, ".error_held"}, err, exp_err);
        check_eq({tag, ".done_cycles"}, done_cycles, 1);
        check_eq({tag, ".lock_cycles"}, lock_cycles, valid ? lat - 1 : 0);
        check_eq({tag, ".bus_rule_violations"}, viol, 0);
        check_eq({tag, ".num_xfers"}, log_q.size(), exp_q.size());
        nlog = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < nlog; i++) begin
            check_eq($sformatf("%s.x%0d.wr", tag, i), log_q[i].wr, exp_q[i].wr);
            check_eq($sformatf("%s.x%0d.addr", tag, i), log_q[i].addr, exp_q[i].addr);
            check_eq($sformatf("%s.x%0d.data", tag, i), log_q[i].data, exp_q[i].data);
        end
    endtask

    function automatic int pick_ws();
        return ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [15:0] keep;
        int          got;
        trig = 1'b0; rwn = 1'b0; chaddr = 2'd0; wdaddr = 12'h0; wdata = 16'h0; wmask = 16'h0;
        chain_en = 1'b0; cwd = 12'h0; setmask = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("reset.bus", {maddr, mwdata, mread, mwrite, lock}, 35'h0);
        check_eq("reset.ir", {ird, done, err}, 18'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        mem[16'h1807] = 16'hFFFF;
        run_op("read0", 1, 2'd1, 12'h807, 16'h0, 16'h04C0, 0, 12'h0, 16'h0, 0, 0, 0, 0, 0);
        check_eq("read0.value", ird, 16'h04C0);

        mem[16'h2C08] = 16'h1234;
        run_op("rmw3", 0, 2'd2, 12'hC08, 16'h0A10, 16'h0E10, 0, 12'h0, 16'h0, 3, 3, 0, 0, 0);
        check_eq("rmw3.mem", mem[16'h2C08], 16'h1A34);

        mem[16'h0C0C] = 16'h0003;
        run_op("chain", 0, 2'd0, 12'h010, 16'h00FF, 16'h000F, 1, 12'hC0C, 16'h1000, 0, 0, 0, 0, 0);
        check_eq("chain.mem", mem[16'h0C0C], 16'h1003);

        run_op("timeout", 0, 2'd1, 12'h222, 16'hFFFF, 16'hFFFF, 1, 12'h333, 16'h8000, 0, 20, 0, 0, 0);
        run_op("badch", 0, 2'd3, 12'h100, 16'h1, 16'h1, 1, 12'h101, 16'h1, 0, 0, 0, 0, 0);
        run_op("maskzero_rd", 1, 2'd2, 12'h040, 16'hFFFF, 16'h0000, 0, 12'h0, 16'h0, 1, 0, 0, 0, 0);
        run_op("retrig", 0, 2'd0, 12'h555, 16'hA5A5, 16'h0FF0, 0, 12'h0, 16'h0, 2, 2, 0, 0, 1);

        // Reset in the middle of the primary write.
        keep = mem_rd(16'h1123);
        ws_q.delete(); ws_q.push_back(0); ws_q.push_back(6); log_q.delete();
        @(negedge clk);
        trig = 1'b1; rwn = 1'b0; chaddr = 2'd1; wdaddr = 12'h123; wdata = 16'hBEEF;
        wmask = 16'hFFFF; chain_en = 1'b0;
        @(negedge clk);
        trig = 1'b0;
        got = 0;
        while (!mwrite && got < 20) begin @(negedge clk); got++; end
        check_eq("rst.write_seen", mwrite, 1'b1);
        done_cycles = 0;
        #2 resetn = 1'b0;
        #1;
        check_eq("rst.bus", {maddr, mwdata, mread, mwrite, lock}, 35'h0);
        check_eq("rst.ir", {ird, done, err}, 18'h0);
        repeat (3) @(negedge clk);
        check_eq("rst.no_done", done_cycles, 0);
        check_eq("rst.mem_untouched", mem[16'h1123], keep);
        resetn = 1'b1;
        last_rd = 16'h0;
        run_op("post_rst", 0, 2'd1, 12'h123, 16'h00F0, 16'h00FF, 1, 12'h124, 16'h0101, 1, 0, 2, 1, 0);

        for (int k = 0; k < 40; k++) begin
            logic [11:0] ra;
            ra = 12'($urandom);
            run_op($sformatf("rnd%0d", k), $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), ra,
                   16'($urandom), ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0) ? ra : 12'($urandom), 16'($urandom),
                   pick_ws(), pick_ws(), pick_ws(), pick_ws(), $urandom_range(0, 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
